// File: rtl/pe_mac_mbank.sv
// pe_mac_mbank: output-stationary systolic MAC processing element.
// Operands, valids and tile_done are forwarded to the neighbours. MACs
// accumulate into the active bank of a ring of NBANK accumulators. A completed
// tile is retired into a drain queue and leaves through a valid/ready
// handshake while the next tile accumulates.
module pe_mac_mbank #(
  parameter int W        = 8,
  parameter int ACCW     = 32,
  parameter int SIGNED   = 1,
  parameter int PIPE_MUL = 0,
  parameter int NBANK    = 2,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            a_valid,
  input  logic            b_valid,
  output logic [W-1:0]    a_out,
  output logic [W-1:0]    b_out,
  output logic            a_valid_out,
  output logic            b_valid_out,
  input  logic            tile_done,
  output logic            tile_done_out,
  output logic [ACCW-1:0] drain_data,
  output logic            drain_ovf,
  output logic            drain_valid,
  input  logic            drain_ready,
  output logic            tile_ready,
  output logic            err_overrun,
  input  logic            err_clr
);

  if (ACCW < 2 * W) begin : g_bad_accw
    $fatal(1, "pe_mac_mbank: ACCW (%0d) must be >= 2*W (%0d)", ACCW, 2 * W);
  end
  if (NBANK < 2 || NBANK > 8) begin : g_bad_nbank
    $fatal(1, "pe_mac_mbank: NBANK (%0d) must be in 2..8", NBANK);
  end

  localparam int            PW   = $clog2(NBANK);
  localparam logic [PW-1:0] LAST = PW'(NBANK - 1);
  localparam logic          SX   = (SIGNED != 0);
  localparam logic          SAT  = (SATURATE != 0);
  localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};

  logic [ACCW-1:0] bank [NBANK];
  logic [NBANK-1:0] ovf;
  logic [PW-1:0]   wr, rd, full_cnt, wr_nx, rd_nx;

  logic [2*W-1:0]  prod, prod_p;
  logic            mv_p, td_p;
  logic [ACCW:0]   prod_x, acc_x, sum;
  logic [ACCW-1:0] acc_nx;
  logic            ovf_now, room, pop, swap, reject;

  // 2W-bit product: operands are widened first so the low 2W bits of the
  // multiply equal the signed or unsigned product
  always_comb begin
    prod = {{W{SX & a[W-1]}}, a} * {{W{SX & b[W-1]}}, b};
  end

  if (PIPE_MUL != 0) begin : g_pipe
    // product, MAC qualifier and tile_done move together so a tile boundary
    // stays paired with its own final MAC
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_p <= '0;
        mv_p   <= 1'b0;
        td_p   <= 1'b0;
      end else begin
        prod_p <= prod;
        mv_p   <= a_valid & b_valid;
        td_p   <= tile_done;
      end
    end
  end else begin : g_nopipe
    // no multiply stage: the accumulate sees the product directly
    always_comb begin
      prod_p = prod;
      mv_p   = a_valid & b_valid;
      td_p   = tile_done;
    end
  end

  // ACCW+1-bit accumulate with overflow detection and optional clamping
  always_comb begin
    prod_x  = {{(ACCW+1-2*W){SX & prod_p[2*W-1]}}, prod_p};
    acc_x   = {SX & bank[wr][ACCW-1], bank[wr]};
    sum     = acc_x + prod_x;
    ovf_now = SX ? (sum[ACCW] ^ sum[ACCW-1]) : sum[ACCW];
    if (ovf_now && SAT) begin
      if (SX) acc_nx = sum[ACCW] ? SMIN : SMAX;
      else    acc_nx = '1;
    end else begin
      acc_nx = sum[ACCW-1:0];
    end
  end

  // ring bookkeeping: a pop in the same cycle frees the slot a full ring needs
  always_comb begin
    room   = (full_cnt < LAST);
    pop    = (full_cnt != '0) & drain_ready;
    swap   = td_p & (room | pop);
    reject = td_p & ~(room | pop);
    wr_nx  = (wr == LAST) ? '0 : wr + PW'(1);
    rd_nx  = (rd == LAST) ? '0 : rd + PW'(1);
  end

  // bank storage: the MAC lands in the active bank, then a swap clears the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NBANK; i++) bank[i] <= '0;
      ovf <= '0;
    end else begin
      if (mv_p) begin
        bank[wr] <= acc_nx;
        if (ovf_now) ovf[wr] <= 1'b1;
      end
      if (swap) begin
        bank[wr_nx] <= '0;
        ovf[wr_nx]  <= 1'b0;
      end
    end
  end

  // write/read pointers and retired-bank count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr       <= '0;
      rd       <= '0;
      full_cnt <= '0;
    end else begin
      if (swap) wr <= wr_nx;
      if (pop)  rd <= rd_nx;
      if (swap && !pop)      full_cnt <= full_cnt + PW'(1);
      else if (pop && !swap) full_cnt <= full_cnt - PW'(1);
    end
  end

  // sticky overrun flag; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_overrun <= 1'b0;
    else if (reject)  err_overrun <= 1'b1;
    else if (err_clr) err_overrun <= 1'b0;
  end

  // unconditional one-cycle forwarding to the neighbouring PEs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out         <= '0;
      b_out         <= '0;
      a_valid_out   <= 1'b0;
      b_valid_out   <= 1'b0;
      tile_done_out <= 1'b0;
    end else begin
      a_out         <= a;
      b_out         <= b;
      a_valid_out   <= a_valid;
      b_valid_out   <= b_valid;
      tile_done_out <= tile_done;
    end
  end

  // drain side views the oldest retired bank
  always_comb begin
    drain_valid = (full_cnt != '0);
    drain_data  = bank[rd];
    drain_ovf   = ovf[rd];
    tile_ready  = room | drain_ready;
  end

endmodule
